// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline segments.
// Segment FSM states, NOP control word and default bundle widths.
package pipe_pkg;

   localparam int CTRL_W_DEF = 12;
   localparam int DATA_W_DEF = 168;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } seg_state_t;

   localparam logic [CTRL_W_DEF-1:0] CTRL_NOP = '0;

   function automatic logic [1:0] occ_of(seg_state_t s);
      logic [1:0] o;
      o = 2'd0;
      case (s)
         ONE:     o = 2'd1;
         FULL:    o = 2'd2;
         default: o = 2'd0;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/segment_entry.sv
// One storage slot of an elastic segment.
// Load-enabled register with synchronous clear (clear wins).
module segment_entry #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         ld,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // Slot contents: cleared on reset, loaded when selected.
   always_ff @(posedge clk) begin
      if (clr)
         q <= '0;
      else if (ld)
         q <= d;
   end

endmodule

// File: rtl/segment_elastic.sv
// Elastic pipeline segment: 2-entry skid buffer with flush.
// Main slot drives the outputs; skid slot absorbs a late stall.
module segment_elastic
   import pipe_pkg::*;
#(
   parameter int CTRL_W         = CTRL_W_DEF,
   parameter int DATA_W         = DATA_W_DEF,
   parameter bit ZERO_BUBBLE    = 1'b1,
   parameter bit FLUSH_KEEPS_IN = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   input  logic              flush,
   output logic [1:0]        occupancy
);

   localparam int W = CTRL_W + DATA_W;

   seg_state_t st, nxt;

   logic         acc, dlv;
   logic         m_ld, m_from_skid, s_ld;
   logic [W-1:0] m_d, m_q, s_q;
   logic [CTRL_W-1:0] m_ctrl;
   logic [DATA_W-1:0] m_data;

   assign acc = in_valid & in_ready;
   assign dlv = out_valid & out_ready;

   assign m_d = m_from_skid ? s_q : {in_ctrl, in_data};
   assign {m_ctrl, m_data} = m_q;

   segment_entry #(.W(W)) u_main (
      .clk (clk),
      .clr (rst),
      .ld  (m_ld),
      .d   (m_d),
      .q   (m_q)
   );

   segment_entry #(.W(W)) u_skid (
      .clk (clk),
      .clr (rst),
      .ld  (s_ld),
      .d   ({in_ctrl, in_data}),
      .q   (s_q)
   );

   // State register; reset dominates flush and handshakes.
   always_ff @(posedge clk) begin
      if (rst)
         st <= EMPTY;
      else
         st <= nxt;
   end

   // Next state and slot load selects; flush overrides traffic.
   always_comb begin
      nxt         = st;
      m_ld        = 1'b0;
      m_from_skid = 1'b0;
      s_ld        = 1'b0;
      if (flush) begin
         nxt = EMPTY;
         if (FLUSH_KEEPS_IN && in_valid) begin
            nxt  = ONE;
            m_ld = 1'b1;
         end
      end else begin
         case (st)
            EMPTY: begin
               if (acc) begin
                  nxt  = ONE;
                  m_ld = 1'b1;
               end
            end
            ONE: begin
               if (acc && dlv) begin
                  m_ld = 1'b1;
               end else if (acc) begin
                  nxt  = FULL;
                  s_ld = 1'b1;
               end else if (dlv) begin
                  nxt = EMPTY;
               end
            end
            FULL: begin
               if (dlv) begin
                  nxt         = ONE;
                  m_ld        = 1'b1;
                  m_from_skid = 1'b1;
               end
            end
            default: nxt = EMPTY;
         endcase
      end
   end

   // Handshake flags and output bundle, decoded from state only.
   always_comb begin
      in_ready  = (st != FULL);
      out_valid = (st != EMPTY);
      occupancy = occ_of(st);
      out_data  = m_data;
      out_ctrl  = m_ctrl;
      if (ZERO_BUBBLE && !out_valid)
         out_ctrl = CTRL_W'(CTRL_NOP);
   end

endmodule

// File: tb/tb_segment_elastic.sv
// Self-checking bench for segment_elastic.
// Scoreboard queue for the default instance plus directed checks.
module tb_segment_elastic;

   localparam int CW = 12;
   localparam int DW = 168;

   typedef struct packed {
      logic [CW-1:0] c;
      logic [DW-1:0] d;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, out_valid, out_ready, flush;
   logic [CW-1:0] in_ctrl, out_ctrl;
   logic [DW-1:0] in_data, out_data;
   logic [1:0]    occupancy;

   logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
   logic [CW-1:0] b_in_ctrl, b_out_ctrl;
   logic [DW-1:0] b_in_data, b_out_data;
   logic [1:0]    b_occupancy;

   int checks = 0;
   int failures = 0;

   beat_t q[$];

   always #5 clk = ~clk;

   segment_elastic dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ctrl   (in_ctrl),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ctrl  (out_ctrl),
      .out_data  (out_data),
      .flush     (flush),
      .occupancy (occupancy)
   );

   segment_elastic #(
      .ZERO_BUBBLE    (1'b0),
      .FLUSH_KEEPS_IN (1'b1)
   ) dut_b (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .in_ctrl   (b_in_ctrl),
      .in_data   (b_in_data),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
      .out_ctrl  (b_out_ctrl),
      .out_data  (b_out_data),
      .flush     (b_flush),
      .occupancy (b_occupancy)
   );

   task automatic chk(input string n, input logic [DW-1:0] a,
                      input logic [DW-1:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", n, a, e);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic iv, input logic [31:0] d,
                      input logic [CW-1:0] c, input logic ordy,
                      input logic fl);
      in_valid  = iv;
      in_data   = {{(DW-32){1'b0}}, d};
      in_ctrl   = c;
      out_ready = ordy;
      flush     = fl;
   endtask

   // Monitor: model occupancy from the queue, pop on deliver, push on accept.
   always @(negedge clk) begin
      int    sz0;
      beat_t e;
      if (rst) begin
         q.delete();
      end else begin
         sz0 = q.size();
         chk("occupancy", {166'd0, occupancy}, DW'(sz0));
         chk("in_ready", {167'd0, in_ready}, {167'd0, sz0 < 2});
         chk("out_valid", {167'd0, out_valid}, {167'd0, sz0 != 0});
         if (!out_valid)
            chk("bubble_ctrl", {156'd0, out_ctrl}, '0);
         if (out_valid && out_ready && sz0 > 0) begin
            e = q.pop_front();
            chk("sb_data", out_data, e.d);
            chk("sb_ctrl", {156'd0, out_ctrl}, {156'd0, e.c});
         end
         if (flush)
            q.delete();
         else if (in_valid && sz0 < 2)
            q.push_back('{c: in_ctrl, d: in_data});
      end
   end

   initial begin
      logic        pend;
      logic        iv;
      logic [31:0] d;
      logic [CW-1:0] c;
      rst = 1'b1;
      drv(0, 0, 0, 0, 0);
      b_in_valid = 0; b_in_data = '0; b_in_ctrl = '0;
      b_out_ready = 0; b_flush = 0;
      step(); step();
      rst = 1'b0;

      // Reset while FULL
      drv(1, 32'h11, 12'h0A1, 0, 0); step();
      drv(1, 32'h12, 12'h0A2, 0, 0); step();
      drv(0, 0, 0, 0, 0);
      chk("full_before_rst", {166'd0, occupancy}, 168'd2);
      rst = 1'b1;
      step(); step();
      chk("rst_out_valid", {167'd0, out_valid}, '0);
      chk("rst_in_ready", {167'd0, in_ready}, 168'd1);
      chk("rst_occ", {166'd0, occupancy}, '0);
      chk("rst_out_ctrl", {156'd0, out_ctrl}, '0);
      chk("rst_out_data", out_data, '0);
      chk("rst_b_out_data", b_out_data, '0);
      rst = 1'b0;

      // Streaming at full rate
      for (int i = 1; i <= 4; i++) begin
         drv(1, i, 12'h100 + CW'(i), 1, 0);
         step();
         chk("stream_data", out_data, DW'(i));
      end
      drv(0, 0, 0, 1, 0); step();

      // Stall fills skid, then drain in order
      drv(1, 32'hA, 12'h00A, 0, 0); step();
      drv(1, 32'hB, 12'h00B, 0, 0); step();
      chk("stall_occ", {166'd0, occupancy}, 168'd2);
      chk("stall_in_ready", {167'd0, in_ready}, '0);
      drv(1, 32'hC, 12'h00C, 0, 0); step(); step();
      chk("stall_hold", out_data, 168'hA);
      drv(0, 0, 0, 1, 0); step();
      chk("skid_second", out_data, 168'hB);
      step();

      // Flush drops held beats and the incoming one
      drv(1, 32'h5, 12'h005, 0, 0); step();
      drv(1, 32'h6, 12'h006, 0, 0); step();
      drv(1, 32'h7, 12'h007, 0, 1); step();
      chk("flush_occ", {166'd0, occupancy}, '0);
      chk("flush_ctrl", {156'd0, out_ctrl}, '0);
      drv(0, 0, 0, 0, 0); step();

      // Same flush on the keep-input instance
      b_in_valid = 1; b_in_data = 168'h5; step();
      b_in_data = 168'h6; step();
      chk("b_full", {166'd0, b_occupancy}, 168'd2);
      b_in_data = 168'h7; b_flush = 1; step();
      chk("b_flush_occ", {166'd0, b_occupancy}, 168'd1);
      chk("b_flush_data", b_out_data, 168'h7);
      b_flush = 0; b_in_valid = 0; b_out_ready = 1; step();
      chk("b_drained", {167'd0, b_out_valid}, '0);

      // Stale control visible in bubble when not zeroed
      b_in_valid = 1; b_in_data = 168'h3; b_in_ctrl = 12'hFFF; step();
      chk("b_bub_data", b_out_data, 168'h3);
      b_in_valid = 0; step();
      chk("b_bub_valid", {167'd0, b_out_valid}, '0);
      chk("b_bub_ctrl", {156'd0, b_out_ctrl}, 168'hFFF);

      drv(1, 32'h3, 12'hFFF, 1, 0); step();
      chk("bub_live_ctrl", {156'd0, out_ctrl}, 168'hFFF);
      drv(0, 0, 0, 1, 0); step();
      chk("bub_zero_ctrl", {156'd0, out_ctrl}, '0);
      chk("bub_keep_data", out_data, 168'h3);

      // out_ready toggling with a held source
      pend = 0; d = 32'h200;
      for (int i = 0; i < 16; i++) begin
         if (!pend) d = d + 1;
         drv(1, d, d[11:0], i[0], 0);
         #3;
         pend = !in_ready;
         step();
      end

      // Random traffic, source holds unaccepted beats
      pend = 0; iv = 0; d = 0; c = 0;
      for (int i = 0; i < 10000; i++) begin
         if (!pend) begin
            iv = 1'($urandom_range(0, 1));
            d  = $urandom;
            c  = CW'($urandom);
         end
         drv(iv, d, c, 1'($urandom_range(0, 1)), 0);
         #3;
         pend = iv && !in_ready;
         step();
      end
      drv(0, 0, 0, 1, 0);
      step(); step(); step();
      chk("drain_occ", {166'd0, occupancy}, '0);
      chk("sb_empty", DW'(q.size()), '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
